// File: rtl/s27_bist_ctrl.sv
// BIST driver and response compactor for the s27 benchmark block.
// Drives LFSR patterns onto G0..G3, holds the s27 reset around each run, folds
// G17 into a 16-bit MISR and flags a match against a golden signature.
module s27_bist_ctrl #(
    parameter int unsigned PAT_COUNT  = 64,
    parameter logic [3:0]  LFSR_SEED  = 4'h9,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk_net,
    input  logic        reset_net,
    input  logic        start,
    output logic        G0,
    output logic        G1,
    output logic        G2,
    output logic        G3,
    output logic        dut_reset,
    input  logic        G17,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {StIdle, StRstDut, StRun, StDone} state_e;

    // An all-zero seed would lock the LFSR, so it is replaced by 4'h1.
    localparam logic [3:0]  SeedEff  = (LFSR_SEED == 4'h0) ? 4'h1 : LFSR_SEED;
    localparam logic [15:0] LastCnt  = 16'(PAT_COUNT - 1);
    localparam logic [15:0] MisrPoly = 16'h1021;
    localparam logic [15:0] SigInit  = 16'hFFFF;

    state_e      state_q, state_d;
    logic [3:0]  pat_q, pat_d;
    logic        dut_reset_q, dut_reset_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] pat_cnt_q, pat_cnt_d;
    logic        rst_cnt_q, rst_cnt_d;

    logic [15:0] misr_next;
    logic [3:0]  lfsr_next;

    // MISR and LFSR next values, used only while in RUN.
    always_comb begin
        misr_next = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ G17) ? MisrPoly : 16'h0000);
        lfsr_next = {pat_q[2:0], pat_q[3] ^ pat_q[2]};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        dut_reset_d = dut_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        sig_d       = sig_q;
        pat_cnt_d   = pat_cnt_q;
        rst_cnt_d   = rst_cnt_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRstDut;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    dut_reset_d = 1'b1;
                    sig_d       = SigInit;
                    pat_cnt_d   = 16'h0000;
                    rst_cnt_d   = 1'b0;
                end
            end
            StRstDut: begin
                // Second edge in this state releases the s27 and loads the seed.
                if (rst_cnt_q) begin
                    state_d     = StRun;
                    dut_reset_d = 1'b0;
                    pat_d       = SeedEff;
                end else begin
                    rst_cnt_d = 1'b1;
                end
            end
            StRun: begin
                sig_d     = misr_next;
                pat_d     = lfsr_next;
                pat_cnt_d = pat_cnt_q + 16'd1;
                if (pat_cnt_q == LastCnt) begin
                    state_d     = StDone;
                    pat_d       = 4'h0;
                    dut_reset_d = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = (misr_next == GOLDEN_SIG);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_net or negedge reset_net) begin
        if (!reset_net) begin
            state_q     <= StIdle;
            pat_q       <= 4'h0;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sig_q       <= SigInit;
            pat_cnt_q   <= 16'h0000;
            rst_cnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            dut_reset_q <= dut_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            sig_q       <= sig_d;
            pat_cnt_q   <= pat_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

    // Every output comes straight from a flop.
    always_comb begin
        G0        = pat_q[0];
        G1        = pat_q[1];
        G2        = pat_q[2];
        G3        = pat_q[3];
        dut_reset = dut_reset_q;
        busy      = busy_q;
        done      = done_q;
        pass      = pass_q;
        signature = sig_q;
    end

endmodule

// File: doc/s27_bist_ctrl.md
Name: s27_bist_ctrl

Overview:
- Built-in self-test driver and response compactor for the s27 sequential benchmark block; it is the other end of the s27 G0..G3 / G17 interface.
- Drives pseudo-random 4-bit patterns onto the DUT primary inputs G0..G3 and holds the DUT reset.
- Compacts the DUT output G17 into a 16-bit MISR signature and compares it against a golden value.
- Sits beside the s27 instance in the optimizer timing example and shares its clock net.

Parameters:
- PAT_COUNT, 64, number of patterns applied per run; legal range 1..65535.
- LFSR_SEED, 4'h9, initial pattern; a value of 0 is replaced by 4'h1.
- GOLDEN_SIG, 16'h0000, expected final signature; pass is asserted on an exact match.

Ports:
- clk_net  in  1  single clock; every flop is rising-edge triggered.
- reset_net  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE and DONE.
- G0  out  1  pattern bit q[0] to the DUT.
- G1  out  1  pattern bit q[1] to the DUT.
- G2  out  1  pattern bit q[2] to the DUT.
- G3  out  1  pattern bit q[3] to the DUT.
- dut_reset  out  1  active-high reset to the DUT's reset input.
- G17  in  1  DUT response, sampled at every RUN clock edge.
- busy  out  1  high in RST_DUT and RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1.
- signature  out  16  current MISR value.

Behaviour:
- Reset (reset_net=0, asynchronous):
  - state=IDLE; G3..G0=0; dut_reset=1; busy=0; done=0; pass=0.
  - signature=16'hFFFF; pattern counter=0; RST_DUT counter=0.
- All outputs are registered.
- FSM states: IDLE, RST_DUT, RUN, DONE.
- IDLE or DONE, start=1 at edge:
  - next state RST_DUT; done<=0, pass<=0, busy<=1.
  - signature<=16'hFFFF; counters cleared; dut_reset stays 1.
- RST_DUT:
  - Holds dut_reset=1 for exactly 2 cycles.
  - On the second edge: next state RUN; dut_reset<=0; G3..G0<=seed (LFSR_SEED, or 4'h1 if LFSR_SEED=0).
- RUN, each rising edge:
  - MISR update: fb=signature[15]^G17; signature<={signature[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0).
  - LFSR advance: q<={q[2:0], q[3]^q[2]}, giving a 15-state maximal sequence.
  - Pattern counter increments.
- RUN, edge on which the counter equals PAT_COUNT-1 (the PAT_COUNT-th pattern is absorbed):
  - next state DONE; G3..G0<=0; dut_reset<=1; busy<=0; done<=1.
  - pass<=(updated signature==GOLDEN_SIG).
- Latency: exactly 2+PAT_COUNT cycles from the start edge to done=1.
- DONE:
  - done, pass and signature hold until the next start or reset.
  - start in DONE begins a new run with the same timing as from IDLE.
- start while busy=1 is ignored and has no effect on the run in progress.
- Reset asserted mid-run aborts immediately to the reset values above; nothing resumes after reset is released.
- The pattern counter width is 16 bits. Wrap-around of the counter is impossible within the legal PAT_COUNT range.
- The LFSR never enters the all-zero state.
- G17 is sampled only in RUN; its value in any other state is don't-care.

Test Plan:
- Reset, then release: all outputs at reset values (signature=16'hFFFF, dut_reset=1, busy=0). Assert reset_net=0 mid-RUN: outputs return to reset values in the same cycle, without waiting for a clock edge.
- Default seed, start pulse: dut_reset high for 2 cycles; then G3..G0 = 1001, 0011, 0110, 1101, 1010 on successive RUN cycles.
- PAT_COUNT=1, G17 tied 0: signature=16'hEFDF, done=1 exactly 3 cycles after start. GOLDEN_SIG=16'hEFDF gives pass=1; GOLDEN_SIG=16'h0000 gives pass=0.
- LFSR_SEED=0: first applied pattern is 0001. Over 15 RUN cycles, 15 distinct nonzero patterns appear, then the sequence repeats.
- Pulse start repeatedly while busy=1: no restart; done=1 still arrives exactly 2+PAT_COUNT cycles after the first start. A start in DONE clears done and pass on the next edge and produces an identical signature for identical G17.
- Connected to the real s27 netlist with PAT_COUNT=64: the same signature is produced on two back-to-back runs. Flipping a single G17 sample (fault injection) changes the signature and drops pass.
